// File: rtl/systolic_matmul_if.sv
// Operand/result bundle for systolic_matmul: start with A/B operands in, busy/done/C out.
interface systolic_matmul_if #(
  parameter int N  = 3,
  parameter int DW = 8
);
  localparam int ACCW = 2*DW + $clog2(N);

  logic                start;
  logic [N*N*DW-1:0]   a_flat;
  logic [N*N*DW-1:0]   b_flat;
  logic                busy;
  logic                done;
  logic [N*N*ACCW-1:0] c_flat;

  modport master (output start, a_flat, b_flat, input busy, done, c_flat);
  modport slave  (input start, a_flat, b_flat, output busy, done, c_flat);
endinterface

// File: rtl/systolic_matmul.sv
// Output-stationary N x N systolic matrix multiplier: C = A x B with fixed 3N-cycle latency.
// A flows east, B flows south; each PE registers its product, then accumulates it.
module systolic_matmul #(
  parameter int N      = 3,
  parameter int DW     = 8,
  parameter int SIGNED = 0
) (
  input logic              clk,
  input logic              rst_n,
  systolic_matmul_if.slave bus
);
  localparam int ACCW = 2*DW + $clog2(N);
  localparam int CW   = $clog2(3*N);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [CW-1:0] LAST_FEED = CW'(3*N-3);
  localparam logic [CW-1:0] LAST_CYC  = CW'(3*N-1);

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic                done_q;
  logic                finishing;
  logic                accept;
  logic [N*N*DW-1:0]   a_q;
  logic [N*N*DW-1:0]   b_q;
  logic [N*N*ACCW-1:0] c_q;

  logic [DW-1:0]          a_west  [N];
  logic [DW-1:0]          b_north [N];
  logic [DW-1:0]          a_in    [N][N];
  logic [DW-1:0]          b_in    [N][N];
  logic [DW-1:0]          a_p0    [N][N];
  logic [DW-1:0]          b_p0    [N][N];
  logic signed [ACCW-1:0] prod_p1 [N][N];
  logic signed [ACCW-1:0] acc_p2  [N][N];

  function automatic logic signed [ACCW-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED != 0) return ACCW'(signed'(x));
    return ACCW'(x);
  endfunction

  // Operands are widened to ACCW first, so the truncated product is exact.
  function automatic logic signed [ACCW-1:0] mac_mul(input logic [DW-1:0] a,
                                                     input logic [DW-1:0] b);
    return ext(a) * ext(b);
  endfunction

  // The completing edge may also accept the next start, giving done-to-done spacing of 3N.
  assign finishing = (state == DRAIN) && (cnt == LAST_CYC);
  assign accept    = bus.start && ((state == IDLE) || finishing);

  // Skewed feed: row i sees A[i][k-i], column j sees B[k-j][j] at step k.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_west[i]  = '0;
      b_north[i] = '0;
      for (int m = 0; m < N; m++) begin
        if ((state == FEED) && (cnt == CW'(m + i))) begin
          a_west[i]  = a_q[(i*N+m)*DW +: DW];
          b_north[i] = b_q[(m*N+i)*DW +: DW];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_edge_w
        assign a_in[i][j] = a_west[i];
      end else begin : g_int_w
        assign a_in[i][j] = a_p0[i][j-1];
      end
      if (i == 0) begin : g_edge_n
        assign b_in[i][j] = b_north[j];
      end else begin : g_int_n
        assign b_in[i][j] = b_p0[i-1][j];
      end
    end
  end

  // p0: forwarded operands, p1: registered product, p2: accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || accept) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_p0[i][j]    <= '0;
          b_p0[i][j]    <= '0;
          prod_p1[i][j] <= '0;
          acc_p2[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_p0[i][j]    <= a_in[i][j];
          b_p0[i][j]    <= b_in[i][j];
          prod_p1[i][j] <= mac_mul(a_in[i][j], b_in[i][j]);
          acc_p2[i][j]  <= acc_p2[i][j] + prod_p1[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a_flat;
      b_q <= bus.b_flat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      c_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (finishing) begin
        done_q <= 1'b1;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            c_q[(i*N+j)*ACCW +: ACCW] <= acc_p2[i][j];
          end
        end
      end
      if (accept) begin
        state <= FEED;
        cnt   <= '0;
      end else begin
        case (state)
          FEED: begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST_FEED) state <= DRAIN;
          end
          DRAIN: begin
            cnt <= cnt + CW'(1);
            if (finishing) state <= IDLE;
          end
          IDLE:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.c_flat = c_q;
endmodule

// File: tb/tb_systolic_matmul.sv
// Scoreboard bench for systolic_matmul across four configurations (bit, unsigned, signed, N=4).
module tb_systolic_matmul;
  localparam int W = 512;
  typedef struct {
    longint         cyc;
    logic [W-1:0]   c;
  } exp_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc   = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_matmul_if #(.N(3), .DW(1)) ifb ();
  systolic_matmul_if #(.N(3), .DW(8)) ifu ();
  systolic_matmul_if #(.N(3), .DW(8)) ifs ();
  systolic_matmul_if #(.N(4), .DW(8)) if4 ();

  systolic_matmul #(.N(3), .DW(1), .SIGNED(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  systolic_matmul #(.N(3), .DW(8), .SIGNED(0)) u_u (.clk(clk), .rst_n(rst_n), .bus(ifu));
  systolic_matmul #(.N(3), .DW(8), .SIGNED(1)) u_s (.clk(clk), .rst_n(rst_n), .bus(ifs));
  systolic_matmul #(.N(4), .DW(8), .SIGNED(0)) u_4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  exp_t qb[$];
  exp_t qu[$];
  exp_t qs[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input int n, input int w, input longint v);
    logic [W-1:0] r = '0;
    for (int e = 0; e < n*n; e++)
      for (int bt = 0; bt < w; bt++) r[e*w+bt] = v[bt];
    return r;
  endfunction

  function automatic logic [W-1:0] model4(input logic [127:0] a, input logic [127:0] b);
    logic [W-1:0] r = '0;
    longint s;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int m = 0; m < 4; m++)
          s += longint'(a[(i*4+m)*8 +: 8]) * longint'(b[(m*4+j)*8 +: 8]);
        r[(i*4+j)*18 +: 18] = s[17:0];
      end
    end
    return r;
  endfunction

  // Monitors: every done pops one expectation (result and cycle of arrival).
  always @(negedge clk) if (rst_n && ifb.done) begin
    exp_t e;
    if (qb.size() == 0) check("b_unexpected_done", 1, 0);
    else begin
      e = qb.pop_front();
      check("b_done_cycle", W'(cyc), W'(e.cyc));
      check("b_c", W'(ifb.c_flat), e.c);
    end
  end

  always @(negedge clk) if (rst_n && ifu.done) begin
    exp_t e;
    if (qu.size() == 0) check("u_unexpected_done", 1, 0);
    else begin
      e = qu.pop_front();
      check("u_done_cycle", W'(cyc), W'(e.cyc));
      check("u_c", W'(ifu.c_flat), e.c);
    end
  end

  always @(negedge clk) if (rst_n && ifs.done) begin
    exp_t e;
    if (qs.size() == 0) check("s_unexpected_done", 1, 0);
    else begin
      e = qs.pop_front();
      check("s_done_cycle", W'(cyc), W'(e.cyc));
      check("s_c", W'(ifs.c_flat), e.c);
    end
  end

  always @(negedge clk) if (rst_n && if4.done) begin
    exp_t e;
    if (q4.size() == 0) check("n4_unexpected_done", 1, 0);
    else begin
      e = q4.pop_front();
      check("n4_done_cycle", W'(cyc), W'(e.cyc));
      check("n4_c", W'(if4.c_flat), e.c);
    end
  end

  initial begin
    longint       e0;
    logic [127:0] ra, rb;
    logic [W-1:0] prev_exp;

    ifb.start = 1'b0; ifb.a_flat = '0; ifb.b_flat = '0;
    ifu.start = 1'b0; ifu.a_flat = '0; ifu.b_flat = '0;
    ifs.start = 1'b0; ifs.a_flat = '0; ifs.b_flat = '0;
    if4.start = 1'b0; if4.a_flat = '0; if4.b_flat = '0;
    prev_exp = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_b_busy", W'(ifb.busy), 0);
    check("rst_b_done", W'(ifb.done), 0);
    check("rst_b_c",    W'(ifb.c_flat), 0);
    check("rst_u_busy", W'(ifu.busy), 0);
    check("rst_u_c",    W'(ifu.c_flat), 0);
    check("rst_s_c",    W'(ifs.c_flat), 0);
    check("rst_4_busy", W'(if4.busy), 0);
    check("rst_4_c",    W'(if4.c_flat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // DW=1: identity x anti-diagonal permutation gives C = B
    @(negedge clk);
    ifb.a_flat = 9'b100010001;
    ifb.b_flat = 9'b001010100;
    ifb.start  = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    e0 = cyc;
    qb.push_back('{e0 + 9, W'(36'h001010100)});
    check("b_busy_e0", W'(ifb.busy), 1);
    repeat (8) @(posedge clk);
    #1;
    check("b_busy_e8", W'(ifb.busy), 1);
    @(posedge clk); #1;
    check("b_busy_e9", W'(ifb.busy), 0);
    check("b_done_e9", W'(ifb.done), 1);
    repeat (3) @(posedge clk);

    // Unsigned full scale; second start at E0+2 and operand changes must be ignored
    @(negedge clk);
    ifu.a_flat = 72'(fill(3, 8, 255));
    ifu.b_flat = 72'(fill(3, 8, 255));
    ifu.start  = 1'b1;
    @(posedge clk); #1;
    ifu.start = 1'b0;
    e0 = cyc;
    qu.push_back('{e0 + 9, fill(3, 18, 195075)});
    ifu.a_flat = 72'(fill(3, 8, 1));
    @(posedge clk);
    @(negedge clk);
    ifu.b_flat = 72'(fill(3, 8, 1));
    ifu.start  = 1'b1;
    @(posedge clk); #1;
    ifu.start = 1'b0;
    check("u_busy_ignored_start", W'(ifu.busy), 1);
    repeat (16) @(posedge clk);
    #1;
    check("u_idle_after", W'(ifu.busy), 0);

    // Signed extremes
    @(negedge clk);
    ifs.a_flat = 72'(fill(3, 8, 128));
    ifs.b_flat = 72'(fill(3, 8, 128));
    ifs.start  = 1'b1;
    @(posedge clk); #1;
    ifs.start = 1'b0;
    qs.push_back('{cyc + 9, fill(3, 18, 49152)});
    repeat (10) @(posedge clk);
    @(negedge clk);
    ifs.b_flat = 72'(fill(3, 8, 127));
    ifs.start  = 1'b1;
    @(posedge clk); #1;
    ifs.start = 1'b0;
    qs.push_back('{cyc + 9, fill(3, 18, -48768)});
    repeat (10) @(posedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    ifs.b_flat = 72'(fill(3, 8, 128));
    ifs.start  = 1'b1;
    @(posedge clk); #1;
    ifs.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("s_busy_before_rst", W'(ifs.busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s_rst_busy", W'(ifs.busy), 0);
    check("s_rst_done", W'(ifs.done), 0);
    check("s_rst_c",    W'(ifs.c_flat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    @(negedge clk);
    ifs.b_flat = 72'(fill(3, 8, 127));
    ifs.start  = 1'b1;
    @(posedge clk); #1;
    ifs.start = 1'b0;
    qs.push_back('{cyc + 9, fill(3, 18, -48768)});
    repeat (11) @(posedge clk);

    // Back-to-back on N=4: each new start lands on the previous completing edge
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      if4.a_flat = ra;
      if4.b_flat = rb;
      if4.start  = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      e0 = cyc;
      if (t > 0) begin
        check("n4_b2b_busy", W'(if4.busy), 1);
        check("n4_b2b_done", W'(if4.done), 1);
      end
      q4.push_back('{e0 + 12, model4(ra, rb)});
      repeat (11) @(posedge clk);
      #1;
      if (t > 0) check("n4_c_hold", W'(if4.c_flat), prev_exp);
      prev_exp = model4(ra, rb);
      @(negedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("n4_final_c_hold", W'(if4.c_flat), prev_exp);
    check("n4_final_idle", W'(if4.busy), 0);

    repeat (20) @(posedge clk);
    check("pending_b", W'(qb.size()), 0);
    check("pending_u", W'(qu.size()), 0);
    check("pending_s", W'(qs.size()), 0);
    check("pending_4", W'(q4.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
